// File: rtl/sfm_streamer_strb_gen_2d.sv
// 2D streamer strobe generator: zero-latency pass-through that masks the last beat of each row.
// Optional `SFM_STRB_GEN_LAST_EN adds out_last_o / out_eot_o row and transfer end markers.
module sfm_streamer_strb_gen_2d #(
  parameter int unsigned DW         = 160,
  parameter int unsigned RESERVED_W = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cfg_row_len_i,
  input  logic [CNT_W-1:0] cfg_n_rows_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_data_o,
  output logic [DW/8-1:0]  out_strb_o,
  output logic             busy_o,
  output logic             done_o
`ifdef SFM_STRB_GEN_LAST_EN
  ,
  output logic             out_last_o,
  output logic             out_eot_o
`endif
);

  localparam int unsigned AW = DW - RESERVED_W;
  localparam int unsigned BW = AW / 8;
  localparam int unsigned LB = $clog2(BW);
  localparam int unsigned RB = RESERVED_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((BW == 0) || ((BW & (BW - 1)) != 0)) begin : g_bw_chk
    $error("sfm_streamer_strb_gen_2d: payload bytes per beat must be a power of 2");
  end
  if ((RESERVED_W % 8) != 0) begin : g_rsv_chk
    $error("sfm_streamer_strb_gen_2d: RESERVED_W must be a multiple of 8");
  end

  logic [1:0]       state_q;
  logic [CNT_W-1:0] row_len_q, n_rows_q;
  logic [CNT_W-1:0] beat_cnt_q, row_cnt_q;
  logic [LB-1:0]    lftovr;
  logic [CNT_W-1:0] beats_per_row;
  logic             run, hs, beat_last, row_last;
  logic [BW-1:0]    last_mask, payload_strb;

  assign run           = (state_q == RUN);
  assign lftovr        = row_len_q[LB-1:0];
  assign beats_per_row = (row_len_q >> LB) + CNT_W'(lftovr != '0);
  assign beat_last     = (beat_cnt_q == beats_per_row - CNT_W'(1));
  assign row_last      = (row_cnt_q == n_rows_q - CNT_W'(1));
  assign hs            = run & in_valid_i & out_ready_i;

  // Only the low lftovr bytes of a short final beat carry payload.
  assign last_mask     = ~({BW{1'b1}} << lftovr);
  assign payload_strb  = (beat_last && (lftovr != '0)) ? last_mask : '1;

  assign out_valid_o = run & in_valid_i;
  assign in_ready_o  = run & out_ready_i;
  assign out_data_o  = in_data_i;
  assign out_strb_o  = run ? {{RB{1'b0}}, payload_strb} : '0;
  assign busy_o      = run;
  assign done_o      = (state_q == DONE);

`ifdef SFM_STRB_GEN_LAST_EN
  assign out_last_o = run & beat_last;
  assign out_eot_o  = run & beat_last & row_last;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      row_len_q  <= '0;
      n_rows_q   <= '0;
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            row_len_q  <= cfg_row_len_i;
            n_rows_q   <= cfg_n_rows_i;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            state_q    <= ((cfg_row_len_i == '0) || (cfg_n_rows_i == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (hs) begin
            if (beat_last) begin
              beat_cnt_q <= '0;
              if (row_last) begin
                row_cnt_q <= '0;
                state_q   <= DONE;
              end else begin
                row_cnt_q <= row_cnt_q + CNT_W'(1);
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfm_streamer_strb_gen_2d.sv
// Directed bench for sfm_streamer_strb_gen_2d: table of transfers plus stall, clear and
// start-ignore sequences, with hand-computed strobe patterns.
module tb_sfm_streamer_strb_gen_2d;

  localparam int unsigned DW    = 160;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned SW    = DW / 8;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             clear_i;
  logic             start_i;
  logic [CNT_W-1:0] cfg_row_len_i;
  logic [CNT_W-1:0] cfg_n_rows_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [DW-1:0]    in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [DW-1:0]    out_data_o;
  logic [SW-1:0]    out_strb_o;
  logic             busy_o;
  logic             done_o;
`ifdef SFM_STRB_GEN_LAST_EN
  logic             out_last_o;
  logic             out_eot_o;
`endif

  always #5 clk = ~clk;

  sfm_streamer_strb_gen_2d #(
    .DW        (160),
    .RESERVED_W(32),
    .CNT_W     (32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .cfg_row_len_i(cfg_row_len_i),
    .cfg_n_rows_i (cfg_n_rows_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_strb_o   (out_strb_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef SFM_STRB_GEN_LAST_EN
    ,
    .out_last_o   (out_last_o),
    .out_eot_o    (out_eot_o)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  // Inputs change at posedge+1, so the negedge sees one stable handshake per cycle.
  always @(negedge clk) if (in_valid_i && in_ready_o) hs_cnt++;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [CNT_W-1:0]  row_len;
    logic [CNT_W-1:0]  n_rows;
    int                nbeats;
    logic [5:0][15:0]  strb;
    int                rowbeats;
    bit                poke_start;
  } xfer_t;

  // Caller is in the drive phase (posedge+1); returns in the drive phase.
  task automatic run_xfer(input xfer_t x);
    int hs0;
    logic [DW-1:0] d;
    hs0 = hs_cnt;
    cfg_row_len_i = x.row_len;
    cfg_n_rows_i  = x.n_rows;
    start_i       = 1'b1;
    in_valid_i    = 1'b1;
    out_ready_i   = 1'b1;
    tick();
    start_i = 1'b0;
    for (int b = 0; b < x.nbeats; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_data_i = d;
      if (x.poke_start && b == 1) begin
        start_i       = 1'b1;
        cfg_row_len_i = 8;
        cfg_n_rows_i  = 1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      chk("strb", DW'(out_strb_o), DW'({4'h0, x.strb[b]}));
      chk("busy", DW'(busy_o), DW'(1));
      chk("data", out_data_o, d);
`ifdef SFM_STRB_GEN_LAST_EN
      chk("last", DW'(out_last_o), DW'((b % x.rowbeats) == x.rowbeats - 1));
      chk("eot", DW'(out_eot_o), DW'(b == x.nbeats - 1));
`endif
      tick();
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("done_pulse", DW'(done_o), DW'(1));
    chk("busy_in_done", DW'(busy_o), DW'(0));
    chk("ready_in_done", DW'(in_ready_o), DW'(0));
    chk("strb_in_done", DW'(out_strb_o), DW'(0));
    tick();
    @(negedge clk);
    chk("done_single", DW'(done_o), DW'(0));
    chk("hs_count", DW'(hs_cnt - hs0), DW'(x.nbeats));
    tick();
    in_valid_i = 1'b0;
  endtask

  xfer_t tbl [7];

  initial begin
    tbl[0] = '{40, 1, 3, {16'h0, 16'h0, 16'h0, 16'h00FF, 16'hFFFF, 16'hFFFF}, 3, 1'b0};
    tbl[1] = '{20, 3, 6, {16'h000F, 16'hFFFF, 16'h000F, 16'hFFFF, 16'h000F, 16'hFFFF}, 2, 1'b0};
    tbl[2] = '{32, 2, 4, {16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 2, 1'b1};
    tbl[3] = '{16, 1, 1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF}, 1, 1'b0};
    tbl[4] = '{1, 2, 2, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0001}, 1, 1'b0};
    tbl[5] = '{0, 3, 0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1, 1'b0};
    tbl[6] = '{24, 0, 0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1, 1'b0};

    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    cfg_row_len_i = '0; cfg_n_rows_i = '0;
    in_valid_i = 1'b1; out_ready_i = 1'b1; in_data_i = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", DW'(busy_o), DW'(0));
    chk("rst_done", DW'(done_o), DW'(0));
    chk("rst_valid", DW'(out_valid_o), DW'(0));
    chk("rst_ready", DW'(in_ready_o), DW'(0));
    chk("rst_strb", DW'(out_strb_o), DW'(0));
    tick();
    rst_ni = 1'b1;
    in_valid_i = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

    // Stall on the short final beat: strobe must hold while ready is low.
    begin
      int hs0;
      hs0 = hs_cnt;
      cfg_row_len_i = 40; cfg_n_rows_i = 1; start_i = 1'b1;
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        chk("stall_pre_strb", DW'(out_strb_o), DW'(20'h0FFFF));
        tick();
      end
      out_ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("stall_ready", DW'(in_ready_o), DW'(0));
        chk("stall_valid", DW'(out_valid_o), DW'(1));
        chk("stall_strb", DW'(out_strb_o), DW'(20'h000FF));
        chk("stall_done", DW'(done_o), DW'(0));
        tick();
      end
      out_ready_i = 1'b1;
      @(negedge clk);
      chk("stall_release_ready", DW'(in_ready_o), DW'(1));
      chk("stall_release_strb", DW'(out_strb_o), DW'(20'h000FF));
      tick();
      @(negedge clk);
      chk("stall_done_pulse", DW'(done_o), DW'(1));
      chk("stall_hs", DW'(hs_cnt - hs0), DW'(3));
      tick();
      in_valid_i = 1'b0;
      tick();
    end

    // Clear mid-transfer (with a competing start) drops the transfer without done.
    begin
      int hs0;
      hs0 = hs_cnt;
      cfg_row_len_i = 64; cfg_n_rows_i = 2; start_i = 1'b1;
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      tick();
      start_i = 1'b0;
      @(negedge clk);
      chk("clr_beat0_strb", DW'(out_strb_o), DW'(20'h0FFFF));
      tick();
      in_valid_i = 1'b0;
      clear_i = 1'b1; start_i = 1'b1; cfg_row_len_i = 8; cfg_n_rows_i = 1;
      tick();
      clear_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b1;
      @(negedge clk);
      chk("clr_busy", DW'(busy_o), DW'(0));
      chk("clr_ready", DW'(in_ready_o), DW'(0));
      chk("clr_strb", DW'(out_strb_o), DW'(0));
      chk("clr_done0", DW'(done_o), DW'(0));
      tick();
      @(negedge clk);
      chk("clr_done1", DW'(done_o), DW'(0));
      chk("clr_hs", DW'(hs_cnt - hs0), DW'(1));
      tick();
      in_valid_i = 1'b0;
      run_xfer('{8, 1, 1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h00FF}, 1, 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
